// File: rtl/coef_load_ctrl_if.sv
// coef_load_ctrl_if
// Groups the host configuration, coefficient stream and coefficient-memory
// write signals of coef_load_ctrl into one bundle.
//   master : host / filter side (drives cfg, abort, filter_busy, stream data)
//   slave  : the load controller (drives s_ready, CIN/CADDR/CLOAD, status)
// Signals:
//   cfg_start, cfg_base, cfg_len : load request, base address, word count
//   abort, filter_busy           : cancel request, datapath-busy indication
//   s_valid, s_data, s_ready     : coefficient stream handshake
//   CIN, CADDR, CLOAD            : coefficient memory write port
//   filter_hold, busy, done, err : status, words_loaded : progress count
interface coef_load_ctrl_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 20
);
   logic              cfg_start;
   logic [ADDR_W-1:0] cfg_base;
   logic [ADDR_W:0]   cfg_len;
   logic              abort;
   logic              filter_busy;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic [DATA_W-1:0] CIN;
   logic [ADDR_W-1:0] CADDR;
   logic              CLOAD;
   logic              filter_hold;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output cfg_start, cfg_base, cfg_len, abort, filter_busy, s_valid, s_data,
      input  s_ready, CIN, CADDR, CLOAD, filter_hold, busy, done, err, words_loaded
   );

   modport slave (
      input  cfg_start, cfg_base, cfg_len, abort, filter_busy, s_valid, s_data,
      output s_ready, CIN, CADDR, CLOAD, filter_hold, busy, done, err, words_loaded
   );
endinterface

// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl
// Coefficient-load sequencer for the FIR distributed-arithmetic coefficient
// memory. Takes a burst of coefficient words over a valid/ready stream and
// writes them to consecutive (wrapping) addresses, holding the filter input
// path off and waiting for the datapath to drain first.
// Ports:
//   clk    : sample-domain clock, all state updates on rising edge
//   resetn : synchronous active-low reset
//   bus    : coef_load_ctrl_if.slave (config, stream, write port, status)
module coef_load_ctrl #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 20,
   parameter int TIMEOUT = 1024
) (
   input logic             clk,
   input logic             resetn,
   coef_load_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0]  MAX_LEN      = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DONE} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   words_q;
   logic [CNT_W-1:0]  idle_cnt;
   logic [DATA_W-1:0] cin_q;
   logic [ADDR_W-1:0] caddr_q;
   logic              cload_q;
   logic              done_q;
   logic              err_q;
   logic              active_q;
   logic              handshake;
   logic              start_bad;
   logic              err_next;

   // A start request is rejected if it asks for zero words or more words
   // than the address space holds.
   assign start_bad = (bus.cfg_len == '0) || (bus.cfg_len > MAX_LEN);

   // Abort suppresses ready so that an aborted cycle can never also
   // complete a handshake.
   assign bus.s_ready = (state == LOAD) && !bus.abort;
   assign handshake   = bus.s_ready && bus.s_valid;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Abort takes priority over both a handshake and the
   // idle timeout; the timeout fires on the TIMEOUT-th consecutive idle
   // LOAD cycle so the error is visible in the first IDLE cycle after it.
   always_comb begin
      state_next = state;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cfg_start) begin
               if (start_bad) begin
                  err_next = 1'b1;
               end else begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (bus.abort) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (!bus.filter_busy) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (bus.abort) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (bus.s_valid) begin
               if (words_q + 1'b1 == len_q) begin
                  state_next = DONE;
               end
            end else if (idle_cnt == TIMEOUT_LAST) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs. The write port is loaded one cycle
   // after each handshake, so the last word's CLOAD lands in the DONE cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q   <= '0;
         len_q    <= '0;
         words_q  <= '0;
         idle_cnt <= '0;
         cin_q    <= '0;
         caddr_q  <= '0;
         cload_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         cload_q  <= handshake;
         done_q   <= (state_next == DONE);
         err_q    <= err_next;
         active_q <= (state_next != IDLE);

         if (handshake) begin
            cin_q   <= bus.s_data;
            caddr_q <= addr_q;
            addr_q  <= addr_q + 1'b1;
            words_q <= words_q + 1'b1;
         end

         if (state == IDLE && bus.cfg_start && !start_bad) begin
            addr_q  <= bus.cfg_base;
            len_q   <= bus.cfg_len;
            words_q <= '0;
         end

         if (state == LOAD && !bus.s_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign bus.CIN          = cin_q;
   assign bus.CADDR        = caddr_q;
   assign bus.CLOAD        = cload_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.filter_hold  = active_q;
   assign bus.busy         = active_q;
   assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// tb_coef_load_ctrl
// Self-checking bench for coef_load_ctrl (ADDR_W=11, DATA_W=20, TIMEOUT=16).
// Expected coefficient writes are queued when a handshake is driven and
// compared when CLOAD appears; load scenarios come from a vector table,
// with hand-written sequences for reject, timeout, abort and reset cases.
module tb_coef_load_ctrl;

   localparam int ADDR_W  = 11;
   localparam int DATA_W  = 20;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      logic [ADDR_W-1:0] base;
      int                len;
      int                busy_cyc;
      bit                gap;
      logic [DATA_W-1:0] first_data;
      int                exp_words;
      int                exp_spacing;
      logic [ADDR_W-1:0] exp_last_addr;
   } vec_t;

   logic clk;
   logic resetn;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;
   int   done_cnt;
   int   err_cnt;
   wr_t  sb[$];
   int   cload_cyc[$];
   logic [ADDR_W-1:0] exp_addr;

   coef_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   coef_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Free-running clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   // Write monitor: every CLOAD must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t e;
      if (bus.CLOAD === 1'b1) begin
         cload_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checkOutput("unexpected_cload", bus.CLOAD, 1'b0);
         end else begin
            e = sb.pop_front();
            checkOutput("cload_addr", bus.CADDR, e.addr);
            checkOutput("cload_data", bus.CIN, e.data);
         end
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1) err_cnt++;
   end

   // Issues a start, optionally keeps the datapath busy, then streams
   // n_words words. Returns on the negedge after the last handshake edge.
   task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int len,
                                input int busy_cyc, input bit gap,
                                input logic [DATA_W-1:0] first_data, input int n_words,
                                output int first_wait, output int drain_bad);
      int waited;
      bus.cfg_base    = base;
      bus.cfg_len     = (ADDR_W+1)'(len);
      bus.cfg_start   = 1'b1;
      bus.filter_busy = (busy_cyc > 0);
      exp_addr        = base;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      drain_bad = 0;
      for (int i = 0; i < busy_cyc; i++) begin
         if (bus.filter_hold !== 1'b1 || bus.s_ready !== 1'b0 || bus.CLOAD !== 1'b0) drain_bad++;
         @(negedge clk);
      end
      bus.filter_busy = 1'b0;
      first_wait = -1;
      for (int w = 0; w < n_words; w++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = first_data + DATA_W'(w);
         waited = 0;
         #1;
         while (bus.s_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
            #1;
         end
         if (w == 0) first_wait = waited;
         if (bus.s_ready !== 1'b1) begin
            checkOutput("handshake_wait", bus.s_ready, 1'b1);
            bus.s_valid = 1'b0;
            return;
         end
         sb.push_back('{addr: exp_addr, data: bus.s_data});
         exp_addr = exp_addr + 1'b1;
         @(negedge clk);
         if (gap && w < n_words - 1) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.s_valid = 1'b0;
   endtask

   vec_t vecs[5];

   initial begin
      int fw, db, d0, e0, k, spacing_bad;
      cyc = 0; pass_cnt = 0; total_cnt = 0; done_cnt = 0; err_cnt = 0;

      vecs[0] = '{11'h000, 4, 0,  1'b0, 20'h00001, 4, 1, 11'h003};
      vecs[1] = '{11'h7FE, 4, 0,  1'b0, 20'hA0000, 4, 1, 11'h001};
      vecs[2] = '{11'h123, 3, 10, 1'b1, 20'h55555, 3, 2, 11'h125};
      vecs[3] = '{11'h7FF, 1, 2,  1'b0, 20'hFFFFF, 1, 1, 11'h7FF};
      vecs[4] = '{11'h400, 6, 0,  1'b1, 20'h12340, 6, 2, 11'h405};

      // Reset state.
      resetn = 1'b0;
      bus.cfg_start = 1'b0; bus.cfg_base = '0; bus.cfg_len = '0; bus.abort = 1'b0;
      bus.filter_busy = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cload", bus.CLOAD, 0);
      checkOutput("rst_cin", bus.CIN, 0);
      checkOutput("rst_caddr", bus.CADDR, 0);
      checkOutput("rst_hold", bus.filter_hold, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_err", bus.err, 0);
      checkOutput("rst_words", bus.words_loaded, 0);
      checkOutput("rst_ready", bus.s_ready, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Table-driven loads.
      foreach (vecs[i]) begin
         $display("[TB] vector %0d base=0x%0h len=%0d", i, vecs[i].base, vecs[i].len);
         cload_cyc.delete();
         d0 = done_cnt; e0 = err_cnt;
         applyStimulus(vecs[i].base, vecs[i].len, vecs[i].busy_cyc, vecs[i].gap,
                       vecs[i].first_data, vecs[i].len, fw, db);
         checkOutput("start_latency", fw, 1);
         if (vecs[i].busy_cyc > 0) checkOutput("drain_hold_bad_cycles", db, 0);
         checkOutput("done_with_last", bus.done, 1);
         checkOutput("cload_with_done", bus.CLOAD, 1);
         checkOutput("last_caddr", bus.CADDR, vecs[i].exp_last_addr);
         checkOutput("words_loaded", bus.words_loaded, vecs[i].exp_words);
         @(negedge clk);
         checkOutput("done_one_cycle", bus.done, 0);
         checkOutput("hold_released", bus.filter_hold, 0);
         checkOutput("busy_released", bus.busy, 0);
         checkOutput("done_pulses", done_cnt - d0, 1);
         checkOutput("err_pulses", err_cnt - e0, 0);
         checkOutput("cload_count", cload_cyc.size(), vecs[i].exp_words);
         spacing_bad = 0;
         for (int j = 1; j < cload_cyc.size(); j++)
            if (cload_cyc[j] - cload_cyc[j-1] != vecs[i].exp_spacing) spacing_bad++;
         checkOutput("cload_spacing", spacing_bad, 0);
         @(negedge clk);
      end

      // Rejected starts: zero length and oversize length.
      bus.cfg_base = 11'h010; bus.cfg_len = 12'd0; bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      checkOutput("reject_len0_err", bus.err, 1);
      checkOutput("reject_len0_hold", bus.filter_hold, 0);
      checkOutput("reject_len0_busy", bus.busy, 0);
      @(negedge clk);
      checkOutput("reject_err_one_cycle", bus.err, 0);
      bus.cfg_len = 12'd2049; bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      checkOutput("reject_len2049_err", bus.err, 1);
      checkOutput("reject_len2049_hold", bus.filter_hold, 0);
      @(negedge clk);

      // cfg_start during LOAD is ignored; original length and addresses hold.
      d0 = done_cnt;
      applyStimulus(11'h200, 3, 0, 1'b0, 20'h11110, 1, fw, db);
      bus.cfg_base = 11'h600; bus.cfg_len = 12'd2; bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      checkOutput("restart_ignored_busy", bus.busy, 1);
      applyStimulus_continue: begin
         int waited;
         for (int w = 0; w < 2; w++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 20'h11111 + DATA_W'(w);
            waited = 0;
            #1;
            while (bus.s_ready !== 1'b1 && waited < 64) begin
               @(negedge clk);
               waited++;
               #1;
            end
            if (bus.s_ready === 1'b1) begin
               sb.push_back('{addr: exp_addr, data: bus.s_data});
               exp_addr = exp_addr + 1'b1;
            end else begin
               checkOutput("restart_handshake_wait", bus.s_ready, 1'b1);
            end
            @(negedge clk);
         end
         bus.s_valid = 1'b0;
      end
      checkOutput("restart_done", bus.done, 1);
      checkOutput("restart_words", bus.words_loaded, 3);
      checkOutput("restart_last_caddr", bus.CADDR, 11'h202);
      @(negedge clk);
      checkOutput("restart_done_pulses", done_cnt - d0, 1);
      @(negedge clk);

      // Idle timeout after two words of an eight-word load.
      cload_cyc.delete();
      e0 = err_cnt;
      applyStimulus(11'h020, 8, 0, 1'b0, 20'h22220, 2, fw, db);
      k = 0;
      while (bus.err !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checkOutput("timeout_latency", k, TIMEOUT);
      checkOutput("timeout_busy", bus.busy, 0);
      checkOutput("timeout_hold", bus.filter_hold, 0);
      checkOutput("timeout_words", bus.words_loaded, 2);
      repeat (3) @(negedge clk);
      checkOutput("timeout_err_pulses", err_cnt - e0, 1);
      checkOutput("timeout_cload_count", cload_cyc.size(), 2);

      // Abort after three words while s_valid is high.
      e0 = err_cnt;
      applyStimulus(11'h040, 8, 0, 1'b0, 20'h33330, 3, fw, db);
      bus.abort = 1'b1; bus.s_valid = 1'b1; bus.s_data = 20'hDEAD0;
      #1;
      checkOutput("abort_ready_low", bus.s_ready, 0);
      @(negedge clk);
      bus.abort = 1'b0; bus.s_valid = 1'b0;
      checkOutput("abort_err", bus.err, 1);
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_hold", bus.filter_hold, 0);
      checkOutput("abort_no_cload", bus.CLOAD, 0);
      checkOutput("abort_words", bus.words_loaded, 3);
      @(negedge clk);
      checkOutput("abort_err_pulses", err_cnt - e0, 1);

      // Synchronous reset in the middle of a load.
      applyStimulus(11'h080, 6, 0, 1'b0, 20'h44440, 2, fw, db);
      resetn = 1'b0; bus.s_valid = 1'b1; bus.s_data = 20'h44442;
      @(negedge clk);
      bus.s_valid = 1'b0;
      checkOutput("midrst_cload", bus.CLOAD, 0);
      checkOutput("midrst_cin", bus.CIN, 0);
      checkOutput("midrst_caddr", bus.CADDR, 0);
      checkOutput("midrst_hold", bus.filter_hold, 0);
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_done", bus.done, 0);
      checkOutput("midrst_err", bus.err, 0);
      checkOutput("midrst_words", bus.words_loaded, 0);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
